// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for the shared data-memory arbiter: core load/store
// path and debug/loader path, with grants and read-back data.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic              dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rdata, core_stall,
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rdata
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rdata, core_stall,
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter: core has priority, a saturating starvation counter
// guarantees debug progress, and a lock state gives debug exclusive ownership.
module dmem_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     bus,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_locked
);
    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             core_gnt, dbg_gnt;

    // Grant decision is purely combinational so the core sees it in the request cycle.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!rst) begin
            if (state_reg == ST_LOCKED) begin
                dbg_gnt = bus.dbg_req;
            end else begin
                core_gnt = bus.core_req && !(bus.dbg_req && (cnt_reg == CNT_MAX));
                dbg_gnt  = bus.dbg_req && !core_gnt;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_addr  = bus.core_addr;
            mem_wdata = bus.core_wdata;
        end else if (dbg_gnt) begin
            mem_addr  = bus.dbg_addr;
            mem_wdata = bus.dbg_wdata;
        end
    end

    assign mem_wr_en = (core_gnt & bus.core_we) | (dbg_gnt & bus.dbg_we);

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        if (state_reg == ST_NORMAL) begin
            if (dbg_gnt && bus.dbg_lock) begin
                state_next = ST_LOCKED;
            end
            if (bus.dbg_req && !dbg_gnt) begin
                cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
            end
        end else begin
            // Release depends only on dbg_lock; an idle debug port keeps ownership.
            if (!bus.dbg_lock) begin
                state_next = ST_NORMAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_NORMAL;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.core_gnt   = core_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.core_rdata = core_gnt ? mem_rdata : '0;
    assign bus.dbg_rdata  = dbg_gnt ? mem_rdata : '0;
    assign bus.core_stall = bus.core_req & ~core_gnt & ~rst;
    assign arb_locked     = (state_reg == ST_LOCKED);
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port (DMEM: synchronous write, combinational read) between the single-cycle core's load/store path and a debug/loader requester. The core has priority. A saturating starvation counter guarantees debug progress, and a lock state lets the debug port own memory for multi-word transfers. Requests denied to the core raise `core_stall`, which freezes the PC and register write-back for that cycle.

## Interface
- `STARVE_LIM`, default 4: consecutive denied debug cycles after which debug wins one contended cycle (≥1).
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clk`  in  1  clock; one clock domain, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `core_req`  in  1  core requests the port this cycle.
- `core_we`  in  1  1 = store, 0 = load.
- `core_addr`  in  ADDR_W  ALU-computed address.
- `core_wdata`  in  DATA_W  store data (already byte-lane formatted).
- `core_gnt`  out  1  core owns the port this cycle.
- `core_rdata`  out  DATA_W  `mem_rdata` when `core_gnt`, else 0.
- `core_stall`  out  1  `core_req & ~core_gnt`.
- `dbg_req`  in  1  debug request.
- `dbg_we`  in  1  debug write.
- `dbg_lock`  in  1  request port ownership after this grant.
- `dbg_addr`  in  ADDR_W  debug address.
- `dbg_wdata`  in  DATA_W  debug write data.
- `dbg_gnt`  out  1  debug owns the port this cycle.
- `dbg_rdata`  out  DATA_W  `mem_rdata` when `dbg_gnt`, else 0.
- `mem_wr_en`  out  1  DMEM write enable.
- `mem_addr`  out  ADDR_W  DMEM address.
- `mem_wdata`  out  DATA_W  DMEM write data.
- `mem_rdata`  in  DATA_W  DMEM combinational read data.
- `arb_locked`  out  1  state == LOCKED (registered).

## Operation
**State register:** NORMAL or LOCKED. Starvation counter `cnt`, width `$clog2(STARVE_LIM+1)`.

**Grant, combinational, at most one per cycle:**
- **rst = 1:** both grants 0, `mem_wr_en` 0, `core_stall` 0.
- **NORMAL:**
  - core wins if `core_req` and not (`dbg_req` and `cnt == STARVE_LIM`).
  - Otherwise debug wins if `dbg_req`.
- **LOCKED:** `core_gnt` is always 0. `dbg_gnt = dbg_req`.

**Port mux:**
- `mem_addr`/`mem_wdata` come from the granted requester.
- `mem_addr`/`mem_wdata` are 0 when neither is granted.
- `mem_wr_en = (core_gnt & core_we) | (dbg_gnt & dbg_we)`.

**Transitions, at the clock edge:**
- NORMAL→LOCKED when `dbg_gnt & dbg_lock`.
- LOCKED→NORMAL when `~dbg_lock`, whether or not `dbg_req` is high.
- rst forces NORMAL from any state.

**Counter:**
- In NORMAL:
  - `+1` (saturating at `STARVE_LIM`) when `dbg_req & ~dbg_gnt`.
  - Cleared to 0 when `dbg_gnt` or `~dbg_req`.
- In LOCKED: held at 0.

**Other rules:**
- A `dbg_lock` asserted on a cycle without `dbg_gnt` has no effect.
- Debug never preempts itself: `dbg_req` low while LOCKED keeps the state LOCKED, with the core stalled, until `dbg_lock` falls.

## Timing
- **Reset values:**
  - state NORMAL, `cnt` 0, `arb_locked` 0.
  - All combinational outputs 0 while rst = 1.
- **Zero-latency grant:** the grant, `mem_*` drive and `rdata` are valid in the same cycle as the request.
- **Writes:** a write commits at the rising edge that ends the granted cycle.
- **Reads:** read data is valid during the granted cycle.
- **Write-then-read:** a read of the same address on the next cycle returns the new data.
- **Stall effect:** a stalled core cycle must not update PC or registers. The core re-presents the same request next cycle.
- **Contention, both requesting continuously:** debug is granted exactly once every `STARVE_LIM+1` cycles.
- **`STARVE_LIM` = 1:** grants alternate core/debug.
- **Lock release:** `arb_locked` falls the cycle after `dbg_lock` deasserts. The core can be granted in that same cycle.
- **Reset mid-lock:** state returns to NORMAL at the reset edge, with no residual stall after rst drops.

## Test plan
- **Reset:** rst = 1 with both requests high → `core_gnt`, `dbg_gnt`, `mem_wr_en`, `core_stall` all 0. After release, `arb_locked` = 0 and the core is granted on the first cycle.
- **Core only:** core store to addr 0x10, data 0xDEADBEEF → `core_gnt` = 1, `mem_wr_en` = 1, `core_stall` = 0. A core load of 0x10 on the next cycle → `core_rdata` = 0xDEADBEEF.
- **Starvation (`STARVE_LIM` = 4):** both requesting continuously → core granted cycles 0–3, debug at cycle 4 with `core_stall` = 1, core again at cycles 5–8, debug at cycle 9.
- **Locked transfer:** debug writes 0x1/0x2/0x3 to 0x100/0x104/0x108 with `dbg_lock` high, and the core raises `core_req` after the first write → `arb_locked` rises, `core_stall` stays 1 until `dbg_lock` drops, then the core is granted. DMEM holds all three words.
- **Reset mid-lock:** rst for 1 cycle while LOCKED → `arb_locked` = 0 after the edge, and the core is granted the cycle after rst drops.
- **Counter clear:** `dbg_req` high 3 cycles against the core, then low 1 cycle, then high again → debug is not granted until 4 further denied cycles have elapsed.
